// File: rtl/issue_scoreboard_if.sv
// Decode/execute/writeback signal bundle for the issue scoreboard.
// The master drives decode, execute-ready and writeback; the slave is the scoreboard.
interface issue_scoreboard_if #(
   parameter int NUM_REGS = 32
);
   logic                id_valid;
   logic                id_ready;
   logic [4:0]          rs1_addr;
   logic [4:0]          rs2_addr;
   logic [4:0]          rd_addr;
   logic                r_type;
   logic                i_type;
   logic                s_type;
   logic                b_type;
   logic                u_type;
   logic                j_type;
   logic                fence_req;
   logic                ex_ready;
   logic                issue_valid;
   logic                wb_valid;
   logic [4:0]          wb_rd;
   logic                kill_valid;
   logic [4:0]          kill_rd;
   logic                fence_done;
   logic [NUM_REGS-1:0] pending;
   logic [3:0]          inflight_cnt;
   logic [31:0]         stall_cycles;
   logic                sb_err;

   modport master (
      output id_valid, rs1_addr, rs2_addr, rd_addr,
             r_type, i_type, s_type, b_type, u_type, j_type,
             fence_req, ex_ready, wb_valid, wb_rd, kill_valid, kill_rd,
      input  id_ready, issue_valid, fence_done, pending, inflight_cnt,
             stall_cycles, sb_err
   );

   modport slave (
      input  id_valid, rs1_addr, rs2_addr, rd_addr,
             r_type, i_type, s_type, b_type, u_type, j_type,
             fence_req, ex_ready, wb_valid, wb_rd, kill_valid, kill_rd,
      output id_ready, issue_valid, fence_done, pending, inflight_cnt,
             stall_cycles, sb_err
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: per-register pending-write tracking, RAW/WAW hold, in-flight cap
// and fence draining in front of the execute stage.
module issue_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int MAX_INFLIGHT = 4,
   parameter bit BYPASS_WB    = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   issue_scoreboard_if.slave sb
);
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t              state_reg, state_next;
   logic [NUM_REGS-1:0] pending_reg, pending_next, clr_vec;
   logic [3:0]          cnt_reg, cnt_next;
   logic [31:0]         stall_reg;
   logic                err_reg, err_next;
   logic                use_rs1, use_rs2, wr_rd;
   logic                busy_rs1, busy_rs2, busy_rd;
   logic                hazard, full, issue_valid, issue_fire;
   logic                wb_live, kill_live, wb_hit, kill_hit, dup_clr, underflow;
   logic [1:0]          n_clr;
   logic [4:0]          cnt_sum;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_clr
         assign clr_vec[gi] = (sb.wb_valid && sb.wb_rd == 5'(gi)) ||
                              (sb.kill_valid && sb.kill_rd == 5'(gi));
      end
   endgenerate

   assign use_rs1 = sb.r_type | sb.i_type | sb.s_type | sb.b_type;
   assign use_rs2 = sb.r_type | sb.s_type | sb.b_type;
   assign wr_rd   = (sb.r_type | sb.i_type | sb.u_type | sb.j_type) && (sb.rd_addr != 5'd0);

   // x0 is never pending, so a zero address can never report busy
   assign busy_rs1 = pending_reg[sb.rs1_addr] && !(BYPASS_WB && clr_vec[sb.rs1_addr]);
   assign busy_rs2 = pending_reg[sb.rs2_addr] && !(BYPASS_WB && clr_vec[sb.rs2_addr]);
   assign busy_rd  = pending_reg[sb.rd_addr]  && !(BYPASS_WB && clr_vec[sb.rd_addr]);

   assign hazard      = (use_rs1 && busy_rs1) || (use_rs2 && busy_rs2) || (wr_rd && busy_rd);
   assign full        = wr_rd && (cnt_reg == 4'(MAX_INFLIGHT));
   assign issue_valid = sb.id_valid && (state_reg == ST_RUN) && !hazard && !full;
   assign issue_fire  = issue_valid && sb.ex_ready;

   assign wb_live   = sb.wb_valid && (sb.wb_rd != 5'd0);
   assign kill_live = sb.kill_valid && (sb.kill_rd != 5'd0);
   assign wb_hit    = wb_live && pending_reg[sb.wb_rd];
   assign kill_hit  = kill_live && pending_reg[sb.kill_rd];
   assign dup_clr   = wb_live && kill_live && (sb.wb_rd == sb.kill_rd);
   assign n_clr     = dup_clr ? {1'b0, wb_hit} : ({1'b0, wb_hit} + {1'b0, kill_hit});
   assign cnt_sum   = {1'b0, cnt_reg} + {4'd0, issue_fire && wr_rd};
   assign underflow = cnt_sum < {3'd0, n_clr};

   always_comb begin
      pending_next = pending_reg & ~clr_vec;
      // a new write to rd outranks a retiring write to the same rd
      if (issue_fire && wr_rd) pending_next[sb.rd_addr] = 1'b1;
      pending_next[0] = 1'b0;
      cnt_next = underflow ? 4'd0 : 4'(cnt_sum - {3'd0, n_clr});
      err_next = err_reg | (wb_live && !wb_hit) | (kill_live && !kill_hit) | dup_clr | underflow;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:   if (sb.fence_req && !issue_fire) state_next = ST_DRAIN;
         ST_DRAIN: if (cnt_next == 4'd0 && pending_next == '0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_RUN;
         pending_reg <= '0;
         cnt_reg     <= 4'd0;
         stall_reg   <= 32'd0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         cnt_reg     <= cnt_next;
         err_reg     <= err_next;
         if (sb.id_valid && !issue_fire && stall_reg != 32'hFFFF_FFFF)
            stall_reg <= stall_reg + 32'd1;
      end
   end

   assign sb.issue_valid  = issue_valid;
   assign sb.id_ready     = issue_fire;
   assign sb.fence_done   = (state_reg == ST_DONE);
   assign sb.pending      = pending_reg;
   assign sb.inflight_cnt = cnt_reg;
   assign sb.stall_cycles = stall_reg;
   assign sb.sb_err       = err_reg;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench: the driver pushes model expectations per cycle, a monitor
// compares them against the DUT half a cycle later.
module tb_issue_scoreboard;
   localparam int  MAXI = 4;
   localparam bit  BYP  = 1'b1;
   localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000,
                          T_B = 6'b000100, T_U = 6'b000010, T_J = 6'b000001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   issue_scoreboard_if #(.NUM_REGS(32)) bus ();
   issue_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(MAXI), .BYPASS_WB(BYP)) dut (
      .clk(clk), .rst_n(rst_n), .sb(bus));

   typedef struct {
      int          txn;
      bit          iv;
      bit          fire;
      bit          fdone;
      bit [31:0]   pend;
      int          cnt;
      bit [31:0]   stall;
      bit          err;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   txn_no = 0;

   // reference model: mode 0=run, 1=draining, 2=done
   bit [31:0] m_pend;
   int        m_cnt;
   bit [31:0] m_stall;
   bit        m_err;
   int        m_mode;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endfunction

   function automatic bit m_clr(int x);
      return (bus.wb_valid && int'(bus.wb_rd) == x) || (bus.kill_valid && int'(bus.kill_rd) == x);
   endfunction

   function automatic bit m_busy(int x);
      return x != 0 && m_pend[x] && !(BYP && m_clr(x));
   endfunction

   function automatic bit m_writes();
      return (bus.r_type || bus.i_type || bus.u_type || bus.j_type) && bus.rd_addr != 0;
   endfunction

   function automatic bit m_offer();
      bit haz;
      haz = ((bus.r_type || bus.i_type || bus.s_type || bus.b_type) && m_busy(int'(bus.rs1_addr))) ||
            ((bus.r_type || bus.s_type || bus.b_type) && m_busy(int'(bus.rs2_addr))) ||
            (m_writes() && m_busy(int'(bus.rd_addr)));
      return bus.id_valid && m_mode == 0 && !haz && !(m_writes() && m_cnt == MAXI);
   endfunction

   function automatic void m_step(bit fire);
      int clears = 0;
      int w = int'(bus.wb_rd);
      int k = int'(bus.kill_rd);
      if (bus.wb_valid && w != 0) begin
         if (m_pend[w]) clears++; else m_err = 1;
      end
      if (bus.kill_valid && k != 0) begin
         if (bus.wb_valid && k == w) m_err = 1;
         else if (m_pend[k]) clears++;
         else m_err = 1;
      end
      if (bus.wb_valid) m_pend[w] = 0;
      if (bus.kill_valid) m_pend[k] = 0;
      if (fire && m_writes()) m_pend[bus.rd_addr] = 1;
      m_pend[0] = 0;
      m_cnt = m_cnt + ((fire && m_writes()) ? 1 : 0) - clears;
      if (m_cnt < 0) begin m_cnt = 0; m_err = 1; end
      if (bus.id_valid && !fire && m_stall != 32'hFFFF_FFFF) m_stall++;
      case (m_mode)
         0: if (bus.fence_req && !fire) m_mode = 1;
         1: if (m_cnt == 0 && m_pend == 0) m_mode = 2;
         default: m_mode = 0;
      endcase
   endfunction

   function automatic void push_exp(bit iv, bit fire);
      exp_t e;
      e.txn = txn_no++; e.iv = iv; e.fire = fire; e.fdone = (m_mode == 2);
      e.pend = m_pend; e.cnt = m_cnt; e.stall = m_stall; e.err = m_err;
      exp_q.push_back(e);
   endfunction

   function automatic int m_pick_pending();
      int cand[$];
      for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
      if (cand.size() == 0) return 0;
      return cand[$urandom_range(0, cand.size() - 1)];
   endfunction

   task automatic drive(input bit v, input logic [5:0] ty, input int a1, input int a2, input int d,
                        input bit exr, input bit fen, input bit wbv, input int wbr,
                        input bit kv, input int kr);
      {bus.r_type, bus.i_type, bus.s_type, bus.b_type, bus.u_type, bus.j_type} = ty;
      bus.id_valid = v; bus.rs1_addr = 5'(a1); bus.rs2_addr = 5'(a2); bus.rd_addr = 5'(d);
      bus.ex_ready = exr; bus.fence_req = fen;
      bus.wb_valid = wbv; bus.wb_rd = 5'(wbr); bus.kill_valid = kv; bus.kill_rd = 5'(kr);
   endtask

   task automatic cycle(input bit v, input logic [5:0] ty, input int a1, input int a2, input int d,
                        input bit exr, input bit fen, input bit wbv, input int wbr,
                        input bit kv, input int kr);
      bit iv, fire;
      @(negedge clk);
      drive(v, ty, a1, a2, d, exr, fen, wbv, wbr, kv, kr);
      iv = m_offer();
      fire = iv && bus.ex_ready;
      push_exp(iv, fire);
      @(posedge clk);
      m_step(fire);
   endtask

   // asserted half a cycle away from any rising edge, so only an asynchronous reset passes
   task automatic do_reset();
      @(negedge clk);
      drive(0, 6'b0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      m_pend = 0; m_cnt = 0; m_stall = 0; m_err = 0; m_mode = 0;
      push_exp(1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         $display("txn %0d: iv=%0b rdy=%0b fd=%0b pend=%08h cnt=%0d stall=%0d err=%0b",
                  e.txn, bus.issue_valid, bus.id_ready, bus.fence_done, bus.pending,
                  bus.inflight_cnt, bus.stall_cycles, bus.sb_err);
         chk("issue_valid", 32'(bus.issue_valid), 32'(e.iv));
         chk("id_ready", 32'(bus.id_ready), 32'(e.fire));
         chk("fence_done", 32'(bus.fence_done), 32'(e.fdone));
         chk("pending", bus.pending, e.pend);
         chk("inflight_cnt", 32'(bus.inflight_cnt), 32'(e.cnt));
         chk("stall_cycles", bus.stall_cycles, e.stall);
         chk("sb_err", 32'(bus.sb_err), 32'(e.err));
      end
   end

   initial begin
      int guard;
      drive(0, 6'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // RAW on x5, released by a same-cycle writeback
      cycle(1, T_I, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      cycle(1, T_R, 5, 1, 6, 1, 0, 0, 0, 0, 0);
      cycle(1, T_R, 5, 1, 6, 1, 0, 1, 5, 0, 0);
      cycle(0, 6'b0, 0, 0, 0, 1, 0, 1, 6, 0, 0);

      // in-flight cap: x1..x4, then a fifth write waits; the wb is not credited that cycle
      for (int r = 1; r <= 4; r++) cycle(1, T_I, 0, 0, r, 1, 0, 0, 0, 0, 0);
      cycle(1, T_I, 0, 0, 7, 1, 0, 0, 0, 0, 0);
      cycle(1, T_I, 0, 0, 7, 1, 0, 1, 1, 0, 0);
      cycle(1, T_I, 0, 0, 7, 1, 0, 0, 0, 0, 0);

      // x0 targets: no tracking, no stall, wb to x0 harmless
      cycle(1, T_I, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cycle(1, T_S, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cycle(1, T_U, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // issue x7 while its previous write retires; then a stray wb to x9
      cycle(0, 6'b0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
      cycle(1, T_J, 0, 0, 7, 1, 0, 1, 7, 0, 0);
      cycle(0, 6'b0, 0, 0, 0, 1, 0, 1, 9, 0, 0);
      cycle(1, T_B, 3, 4, 0, 1, 0, 0, 0, 0, 0);

      // fence with two writes in flight
      cycle(0, 6'b0, 0, 0, 0, 1, 0, 1, 3, 0, 0);
      cycle(0, 6'b0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      guard = 0;
      while (m_mode != 2 && guard < 20) begin
         cycle(1, T_I, 0, 0, 10, 1, 0, 1, m_pick_pending(), 0, 0);
         guard++;
      end
      checks++;
      if (guard >= 20) begin
         errors++;
         $display("FAIL fence_drain: got no drain after %0d cycles required fewer than 20", guard);
      end
      cycle(1, T_I, 0, 0, 10, 1, 0, 0, 0, 0, 0);
      cycle(1, T_I, 0, 0, 10, 1, 0, 0, 0, 0, 0);

      // reset in the middle of a drain
      cycle(1, T_I, 0, 0, 11, 1, 0, 0, 0, 0, 0);
      cycle(0, 6'b0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      cycle(1, T_I, 0, 0, 12, 1, 0, 0, 0, 0, 0);
      do_reset();

      // randomized traffic on a small register window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         bit wbv, kv;
         int wbr, kr;
         if (n % 200 == 199) do_reset();
         wbv = ($urandom_range(0, 9) < 4);
         wbr = ($urandom_range(0, 99) == 0) ? $urandom_range(0, 9) : m_pick_pending();
         kv  = ($urandom_range(0, 19) == 0);
         kr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : m_pick_pending();
         if (wbv && wbr == 0 && $urandom_range(0, 1) == 0) wbv = 0;
         if (kv && kr == 0) kv = 0;
         cycle(($urandom_range(0, 3) != 0), 6'(6'b1 << $urandom_range(0, 5)),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
               wbv, wbr, kv, kr);
      end

      @(negedge clk);
      #4;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
